// File: rtl/peri_inputs_db.sv
// Memory-mapped input peripheral: per-channel 2-FF synchroniser, counter debounce,
// sticky write-1-to-clear change flags, interrupt mask and level interrupt.
module peri_inputs_db #(
    parameter int N_CH            = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N_CH-1:0] inputs_i,
    input  logic            we_i,
    input  logic [1:0]      addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o,
    output logic [N_CH-1:0] debounced_o,
    output logic            irq_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ADDR_STATE  = 2'd0,
        ADDR_CHANGE = 2'd1,
        ADDR_MASK   = 2'd2,
        ADDR_RSVD   = 2'd3
    } addr_e;

    logic [N_CH-1:0]  sync_meta;
    logic [N_CH-1:0]  sync_s;
    logic [N_CH-1:0]  deb;
    logic [N_CH-1:0]  change;
    logic [N_CH-1:0]  mask;
    logic [N_CH-1:0]  chg_set;
    logic [N_CH-1:0]  clr_bits;
    logic [CNT_W-1:0] cnt [N_CH];
    logic             unused_wdata;

    assign unused_wdata = ^wdata_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= inputs_i;
            sync_s    <= sync_meta;
        end
    end

    // A channel is accepted on the edge where it has already differed for CNT_MAX edges
    always_comb begin
        chg_set = '0;
        for (int k = 0; k < N_CH; k++) begin
            chg_set[k] = (sync_s[k] != deb[k]) && (cnt[k] == CNT_MAX);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            deb <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (sync_s[k] == deb[k]) begin
                    cnt[k] <= '0;
                end else if (chg_set[k]) begin
                    deb[k] <= sync_s[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    assign clr_bits = (we_i && (addr_i == ADDR_CHANGE)) ? wdata_i[N_CH-1:0] : '0;

    // Set is OR-ed in after the clear so a colliding W1C never loses a new event
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            change <= '0;
            mask   <= '0;
        end else begin
            change <= (change & ~clr_bits) | chg_set;
            if (we_i && (addr_i == ADDR_MASK)) begin
                mask <= wdata_i[N_CH-1:0];
            end
        end
    end

    assign irq_o       = |(change & mask);
    assign debounced_o = deb;

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            ADDR_STATE:  rdata_o = 32'(deb);
            ADDR_CHANGE: rdata_o = 32'(change);
            ADDR_MASK:   rdata_o = 32'(mask);
            ADDR_RSVD:   rdata_o = '0;
            default:     rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_peri_inputs_db.sv
// Self-checking bench for peri_inputs_db: directed scenarios plus randomized traffic
// compared against a sliding-window behavioural model.
module tb_peri_inputs_db;

    localparam int N  = 16;
    localparam int DC = 4;
    localparam int CW = 3;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [N-1:0]  inputs_i;
    logic          we_i;
    logic [1:0]    addr_i;
    logic [31:0]   wdata_i;
    logic [31:0]   rdata_o;
    logic [N-1:0]  debounced_o;
    logic          irq_o;

    int n_vec = 0;
    int n_err = 0;

    // Model: raw samples delayed two edges, then a level is accepted once the
    // last DC delayed samples since the previous acceptance all disagree with it.
    logic [N-1:0]    m_r1, m_r2, m_deb, m_chg, m_mask;
    logic [DC-1:0]   m_hist [N];
    int              m_len  [N];

    always #5 clk_i = ~clk_i;

    peri_inputs_db #(
        .N_CH(N),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .inputs_i(inputs_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .rdata_o(rdata_o),
        .debounced_o(debounced_o),
        .irq_o(irq_o)
    );

    task automatic model_reset();
        m_r1 = '0; m_r2 = '0; m_deb = '0; m_chg = '0; m_mask = '0;
        for (int k = 0; k < N; k++) begin
            m_hist[k] = '0;
            m_len[k]  = 0;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] set, clr;
        set = '0;
        for (int k = 0; k < N; k++) begin
            m_hist[k] = {m_hist[k][DC-2:0], m_r2[k]};
            if (m_len[k] < DC) m_len[k]++;
            if (m_len[k] == DC && m_hist[k] == {DC{~m_deb[k]}}) begin
                set[k]   = 1'b1;
                m_len[k] = 0;
            end
        end
        m_deb = m_deb ^ set;
        clr   = (we_i && addr_i == 2'd1) ? wdata_i[N-1:0] : '0;
        m_chg = (m_chg & ~clr) | set;
        if (we_i && addr_i == 2'd2) m_mask = wdata_i[N-1:0];
        m_r2 = m_r1;
        m_r1 = inputs_i;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd1:    return 32'(m_chg);
            2'd2:    return 32'(m_mask);
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk_i);
        if (!reset_i) model_edge();
        @(negedge clk_i);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        addr_i  = a;
        wdata_i = d;
        we_i    = 1'b1;
        step();
        we_i    = 1'b0;
    endtask

    task automatic test_reset();
        do_write(2'd2, 32'h0000FFFF);
        inputs_i = '1;
        repeat (8) step();
        n_vec++;
        if (debounced_o !== 16'hFFFF || irq_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: deb=%h irq=%b, required deb=FFFF irq=1", debounced_o, irq_o);
        end
        #2 reset_i = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (debounced_o !== '0 || irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: deb=%h irq=%b, required 0", debounced_o, irq_o);
        end
        for (int a = 0; a < 4; a++) begin
            addr_i = 2'(a);
            #1;
            n_vec++;
            if (rdata_o !== 32'h0) begin
                n_err++;
                $display("FAIL reset_rdata addr %0d: got %h, required 0", a, rdata_o);
            end
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int i = 1; i <= DC + 2; i++) begin
            step();
            n_vec++;
            if (debounced_o !== ((i == DC + 2) ? 16'hFFFF : 16'h0000)) begin
                n_err++;
                $display("FAIL reset_settle edge %0d: deb=%h", i, debounced_o);
            end
        end
        addr_i = 2'd0;
        #1;
        n_vec++;
        if (rdata_o !== 32'h0000FFFF) begin
            n_err++;
            $display("FAIL reset_state: got %h, required 0000ffff", rdata_o);
        end
        addr_i = 2'd1;
        #1;
        n_vec++;
        if (rdata_o !== 32'h0000FFFF) begin
            n_err++;
            $display("FAIL reset_change: got %h, required 0000ffff", rdata_o);
        end
    endtask

    task automatic test_clean_edge();
        inputs_i = '0;
        repeat (8) step();
        do_write(2'd1, 32'h0000FFFF);
        n_vec++;
        if (rdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL clean_clear: CHANGE=%h, required 0", rdata_o);
        end
        inputs_i = 16'h0008;
        for (int i = 1; i <= DC + 2; i++) begin
            step();
            n_vec++;
            if (debounced_o[3] !== (i == DC + 2) || debounced_o !== m_deb || irq_o !== 1'b0) begin
                n_err++;
                $display("FAIL clean_edge edge %0d: deb=%h model=%h irq=%b", i, debounced_o, m_deb, irq_o);
            end
        end
        n_vec++;
        if (rdata_o !== 32'h00000008) begin
            n_err++;
            $display("FAIL clean_change: got %h, required 00000008", rdata_o);
        end
    endtask

    task automatic test_glitch();
        logic pat [14] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        addr_i = 2'd1;
        for (int i = 0; i < 14; i++) begin
            inputs_i[5] = pat[i];
            step();
            n_vec++;
            if (debounced_o[5] !== 1'b0 || rdata_o[5] !== 1'b0 || debounced_o !== m_deb) begin
                n_err++;
                $display("FAIL glitch step %0d: deb=%h change=%h model=%h", i, debounced_o, rdata_o, m_deb);
            end
        end
    endtask

    task automatic test_irq_w1c();
        do_write(2'd1, 32'h0000FFFF);
        do_write(2'd2, 32'h00000008);
        n_vec++;
        if (irq_o !== 1'b0) begin
            n_err++;
            $display("FAIL irq_idle: irq=%b, required 0", irq_o);
        end
        inputs_i[3] = 1'b0;
        repeat (DC + 2) step();
        n_vec++;
        if (irq_o !== 1'b1 || debounced_o[3] !== 1'b0) begin
            n_err++;
            $display("FAIL irq_raise: irq=%b deb3=%b, required 1 and 0", irq_o, debounced_o[3]);
        end
        do_write(2'd1, 32'h00000001);
        n_vec++;
        if (irq_o !== 1'b1) begin
            n_err++;
            $display("FAIL irq_other_clear: irq=%b, required 1", irq_o);
        end
        do_write(2'd1, 32'h00000008);
        n_vec++;
        if (irq_o !== 1'b0 || irq_o !== |(m_chg & m_mask)) begin
            n_err++;
            $display("FAIL irq_w1c: irq=%b, required 0", irq_o);
        end
    endtask

    task automatic test_collision();
        inputs_i[3] = 1'b1;
        repeat (DC + 1) step();
        n_vec++;
        if (debounced_o[3] !== 1'b0) begin
            n_err++;
            $display("FAIL collide_pre: deb3=%b, required 0", debounced_o[3]);
        end
        addr_i  = 2'd1;
        wdata_i = 32'h00000008;
        we_i    = 1'b1;
        step();
        we_i    = 1'b0;
        n_vec++;
        if (debounced_o[3] !== 1'b1 || rdata_o !== 32'h00000008 || rdata_o !== m_read(2'd1) || irq_o !== 1'b1) begin
            n_err++;
            $display("FAIL collide: deb3=%b change=%h irq=%b, required 1 00000008 1", debounced_o[3], rdata_o, irq_o);
        end
    endtask

    task automatic test_reset_midcount();
        inputs_i[7] = 1'b1;
        repeat (4) step();
        #2 reset_i = 1'b1;
        model_reset();
        addr_i = 2'd1;
        #1;
        n_vec++;
        if (debounced_o[7] !== 1'b0 || rdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL midcount_reset: deb7=%b change=%h, required 0 0", debounced_o[7], rdata_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int i = 1; i <= DC + 2; i++) begin
            step();
            n_vec++;
            if (debounced_o[7] !== (i == DC + 2)) begin
                n_err++;
                $display("FAIL midcount_restart edge %0d: deb7=%b", i, debounced_o[7]);
            end
        end
        n_vec++;
        if (debounced_o !== 16'h0088 || rdata_o !== 32'h00000088) begin
            n_err++;
            $display("FAIL midcount_final: deb=%h change=%h, required 0088 00000088", debounced_o, rdata_o);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 2) == 0) inputs_i = inputs_i ^ (N'(1) << $urandom_range(0, N - 1));
            if ($urandom_range(0, 19) == 0) inputs_i = inputs_i ^ N'($urandom);
            we_i    = ($urandom_range(0, 5) == 0);
            addr_i  = 2'($urandom_range(0, 3));
            wdata_i = $urandom;
            step();
            we_i   = 1'b0;
            addr_i = 2'($urandom_range(0, 3));
            #1;
            n_vec++;
            if (debounced_o !== m_deb || irq_o !== |(m_chg & m_mask) || rdata_o !== m_read(addr_i)) begin
                n_err++;
                $display("FAIL random cyc %0d: deb=%h/%h irq=%b/%b rdata[%0d]=%h/%h", cyc, debounced_o, m_deb,
                         irq_o, |(m_chg & m_mask), addr_i, rdata_o, m_read(addr_i));
            end
        end
    endtask

    initial begin
        reset_i  = 1'b1;
        inputs_i = '0;
        we_i     = 1'b0;
        addr_i   = 2'd0;
        wdata_i  = 32'h0;
        model_reset();
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        test_reset();
        test_clean_edge();
        test_glitch();
        test_irq_w1c();
        test_collision();
        test_reset_midcount();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
